// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   XLEN            address / instruction width
//   RESET_PC_DEF    default first fetch address after reset
//   FIFO_DEPTH_DEF  default prefetch queue depth
//   fetch_state_e   fetch FSM states
//   if_entry_t      one prefetch queue entry {pc, ins, fault}
//   word_align()    clears the byte-offset bits of an address
package if_pkg;

  localparam int unsigned XLEN           = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    REQ  = 2'd1,  // request outstanding, data will be kept
    DROP = 2'd2,  // request outstanding, data will be discarded
    HALT = 2'd3   // bus fault seen, wait for redirect
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
    logic            fault;
  } if_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous show-ahead FIFO of prefetch entries.
//   clk, rst    clock, asynchronous active-low reset
//   push        write push_data at the tail (ignored when full and not popping)
//   push_data   entry to write
//   pop         remove the head (ignored when empty)
//   flush       empty the queue; overrides push and pop in the same cycle
//   count       number of valid entries
//   valid       queue non-empty (registered)
//   head        current head entry, all-zero when empty (registered)
// The head and valid outputs are flops computed from the next-state of the
// queue, so a word pushed into an empty queue is visible the next cycle.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  if_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   valid,
  output if_entry_t              head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if_entry_t     mem_q [DEPTH];
  if_entry_t     mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  if_entry_t     head_q, head_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full queue can still accept a push when the head leaves this cycle.
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    valid_d = (count_d != '0);
    // mem_d already holds this cycle's write, so a push into an empty
    // queue becomes the head directly.
    head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign count = count_q;
  assign valid = valid_q;
  assign head  = head_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a prefetch queue.
//   clk, rst        clock, asynchronous active-low reset
//   redirect_valid  flush the queue and restart fetch at redirect_pc
//   redirect_pc     new fetch address (byte offset ignored)
//   mem_req         fetch request (registered)
//   mem_addr        fetch address, held while mem_req && !mem_ack (registered)
//   mem_ack         request complete; mem_rdata / mem_err valid this cycle
//   mem_rdata       fetched instruction word
//   mem_err         bus fault on this fetch
//   ins_valid       queue head valid
//   ins_ready       decode accepts the head this cycle
//   ins, ins_pc     head instruction and its PC
//   ins_fault       head is a fetch fault (ins is zero)
//   dbg_state       current fetch FSM state
//
// Handshakes: memory side is req/ack -- mem_req stays high with a stable
// mem_addr until the cycle mem_ack is seen, at most one request is ever
// outstanding. Decode side is valid/ready -- the head transfers in every cycle
// with ins_valid && ins_ready; ins_valid never depends on ins_ready.
//
// A redirect has absolute priority: the queue is emptied, the same-cycle pop
// and ack data are ignored, and if a request is still in flight it is left to
// complete in DROP with its data thrown away before fetching the new target.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned     FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins,
  output logic [XLEN-1:0] ins_pc,
  output logic            ins_fault,
  output fetch_state_e    dbg_state
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;

  logic            fifo_push;
  logic            fifo_pop;
  if_entry_t       push_entry;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_after;
  logic            head_valid;
  if_entry_t       head;
  logic            has_space;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_next_seq;

  always_comb begin
    redirect_target = word_align(redirect_pc);
    pc_next_seq     = pc_q + XLEN'(4);

    fifo_push        = (state_q == REQ) && mem_ack && !redirect_valid;
    fifo_pop         = head_valid && ins_ready && !redirect_valid;
    push_entry.pc    = pc_q;
    push_entry.ins   = mem_err ? '0 : mem_rdata;
    push_entry.fault = mem_err;

    // Occupancy once this cycle's push/pop land; a new request is only
    // issued if its data is guaranteed a free slot on return.
    count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    has_space   = count_after < CW'(FIFO_DEPTH);
  end

  // Fetch FSM next-state and registered memory-side outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    if (redirect_valid) begin
      pc_d = redirect_target;
      if (((state_q == REQ) || (state_q == DROP)) && !mem_ack) begin
        // Bus transaction must finish at its original address.
        state_d = DROP;
      end else begin
        state_d    = REQ;
        mem_req_d  = 1'b1;
        mem_addr_d = redirect_target;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (has_space) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        REQ: begin
          if (mem_ack) begin
            pc_d = pc_next_seq;
            if (mem_err) begin
              state_d   = HALT;
              mem_req_d = 1'b0;
            end else if (has_space) begin
              state_d    = REQ;
              mem_req_d  = 1'b1;
              mem_addr_d = pc_next_seq;
            end else begin
              state_d   = IDLE;
              mem_req_d = 1'b0;
            end
          end
        end
        DROP: begin
          if (mem_ack) begin
            if (has_space) begin
              state_d    = REQ;
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
            end else begin
              state_d   = IDLE;
              mem_req_d = 1'b0;
            end
          end
        end
        HALT: begin
          mem_req_d = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  if_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .flush    (redirect_valid),
    .count    (fifo_count),
    .valid    (head_valid),
    .head     (head)
  );

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ins_valid = head_valid;
  assign ins       = head.ins;
  assign ins_pc    = head.pc;
  assign ins_fault = head.fault;
  assign dbg_state = state_q;

endmodule
